// File: rtl/mem_target_bank_pkg.sv
// Shared definitions for the multi-bank PCI memory target: command bit
// positions, command class masks, FSM encoding and a legality helper.
package mem_target_bank_pkg;

  // One-hot decoded pci_cmd bit positions
  localparam int CMD_MRD = 6;   // Memory Read
  localparam int CMD_MWR = 7;   // Memory Write
  localparam int CMD_MRM = 12;  // Memory Read Multiple
  localparam int CMD_MRL = 14;  // Memory Read Line
  localparam int CMD_MWI = 15;  // Memory Write and Invalidate

  localparam logic [15:0] RD_CMD_MASK = 16'((1 << CMD_MRD) | (1 << CMD_MRM) | (1 << CMD_MRL));
  localparam logic [15:0] WR_CMD_MASK = 16'((1 << CMD_MWR) | (1 << CMD_MWI));

  // Width of one byte lane in the bank RAMs
  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_XFER  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  // A command is acceptable when it belongs to the class implied by the
  // transfer direction and the start address is dword aligned.
  function automatic logic access_legal(input logic [15:0] cmd,
                                        input logic        wrdn,
                                        input logic [1:0]  addr_lo);
    logic cmd_ok;
    cmd_ok = wrdn ? (|(cmd & WR_CMD_MASK)) : (|(cmd & RD_CMD_MASK));
    return cmd_ok && (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/mem_target_ram.sv
// One memory bank: single-port RAM with per-byte-lane write enables and a
// registered read. Each lane is its own narrow array so every lane maps onto
// an independent block RAM column with no cross-lane write hazards.
module mem_target_ram
  import mem_target_bank_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic                 CLK,
  input  logic [AW-1:0]        addr,
  input  logic [DW/LANE_W-1:0] we,
  input  logic [DW-1:0]        wdata,
  output logic [DW-1:0]        rdata
);

  localparam int DEPTH = 2 ** AW;

  genvar gi;
  generate
    for (gi = 0; gi < DW / LANE_W; gi++) begin : g_lane
      logic [LANE_W-1:0] mem [DEPTH];
      logic [LANE_W-1:0] q_reg;

      // Lane write under its enable; read is registered every cycle
      always_ff @(posedge CLK) begin
        if (we[gi]) begin
          mem[addr] <= wdata[gi*LANE_W +: LANE_W];
        end
        q_reg <= mem[addr];
      end

      assign rdata[gi*LANE_W +: LANE_W] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_target_bank.sv
// PCI target back-end with NBAR word-addressed scratch-pad banks. Supports
// bursts with an auto-incrementing pointer, byte enables, initial wait
// states, disconnect at bank end and target abort on illegal accesses.
module mem_target_bank
  import mem_target_bank_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 6,
  parameter int NBAR        = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          s_wrdn,
  input  logic [15:0]   pci_cmd,
  input  logic [31:0]   addr,
  input  logic [7:0]    base_hit,
  input  logic          s_data,
  input  logic          s_data_vld,
  input  logic [3:0]    s_cbe,
  input  logic [DW-1:0] adio_out,
  output logic [DW-1:0] adio_in,
  output logic          s_ready,
  output logic          s_term,
  output logic          s_abort,
  output logic          busy
);

  localparam int              DEPTH     = 2 ** AW;
  localparam int              BW        = (NBAR > 1) ? $clog2(NBAR) : 1;
  localparam logic [AW-1:0]   PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_STATES);

  state_e          state_reg, state_next;
  logic [AW-1:0]   ptr_reg, ptr_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [BW-1:0]   bank_reg, bank_next;
  logic            dir_wr_reg, dir_wr_next;
  logic            done_reg, done_next;

  logic            hit_any;
  logic [BW-1:0]   hit_bank;
  logic            hit_legal;
  logic            ram_we_any;
  logic [AW-1:0]   ram_addr;
  logic [3:0]      lane_we;
  logic [DW-1:0]   bank_q [NBAR];
  logic [DW-1:0]   rdq;
  logic            unused_bits;

  // Only the low address bits and the low NBAR hit bits carry meaning
  assign unused_bits = ^{addr, base_hit};

  // Hit decode: lowest set base_hit bit below NBAR selects the bank
  always_comb begin
    hit_any  = 1'b0;
    hit_bank = '0;
    for (int b = NBAR - 1; b >= 0; b--) begin
      if (base_hit[b]) begin
        hit_any  = 1'b1;
        hit_bank = BW'(b);
      end
    end
  end

  assign hit_legal = access_legal(pci_cmd, s_wrdn, addr[1:0]);

  // State and transaction context registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      bank_reg   <= '0;
      dir_wr_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      cnt_reg    <= cnt_next;
      bank_reg   <= bank_next;
      dir_wr_reg <= dir_wr_next;
      done_reg   <= done_next;
    end
  end

  // Next-state, pointer and write-strobe logic
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    cnt_next    = cnt_reg;
    bank_next   = bank_reg;
    dir_wr_next = dir_wr_reg;
    done_next   = done_reg;
    ram_we_any  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (hit_any) begin
          bank_next   = hit_bank;
          ptr_next    = addr[AW+1:2];
          dir_wr_next = s_wrdn;
          done_next   = 1'b0;
          if (!hit_legal) begin
            state_next = ST_ABORT;
          end else if (WAIT_STATES > 0) begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = ST_XFER;
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          state_next = ST_XFER;
          cnt_next   = 4'd0;
        end
      end
      ST_XFER: begin
        // The last word completes once; afterwards the pointer is parked
        // at the bank end and further data phases touch nothing.
        if (s_data_vld && !done_reg) begin
          ram_we_any = dir_wr_reg;
          if (ptr_reg == PTR_LAST) begin
            done_next = 1'b1;
          end else begin
            ptr_next = ptr_reg + AW'(1);
          end
        end
        if (!s_data) begin
          state_next = ST_IDLE;
        end
      end
      ST_ABORT: begin
        if (!s_data) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Writes use the current pointer; otherwise the RAM looks ahead at the
  // next pointer so its registered output is the prefetched read word.
  assign ram_addr = ram_we_any ? ptr_reg : ptr_next;
  assign lane_we  = ram_we_any ? ~s_cbe : 4'b0000;

  genvar gi;
  generate
    for (gi = 0; gi < NBAR; gi++) begin : g_bank
      logic [3:0] bank_we;
      assign bank_we = (bank_reg == BW'(gi)) ? lane_we : 4'b0000;

      mem_target_ram #(
        .DW (DW),
        .AW (AW)
      ) u_ram (
        .CLK   (CLK),
        .addr  (ram_addr),
        .we    (bank_we),
        .wdata (adio_out),
        .rdata (bank_q[gi])
      );
    end
  endgenerate

  assign rdq = bank_q[bank_reg];

  assign s_ready = (state_reg == ST_XFER);
  assign s_term  = (state_reg == ST_XFER) && (ptr_reg == PTR_LAST);
  assign s_abort = (state_reg == ST_ABORT);
  assign busy    = (state_reg != ST_IDLE);

  // Drive the shared adio bus only during read data phases
  assign adio_in = ((state_reg == ST_XFER) && s_data && !dir_wr_reg) ? rdq : {DW{1'bz}};

endmodule

// File: tb/tb_mem_target_bank.sv
// Directed bench for mem_target_bank: a zero-wait instance carries the main
// traffic; a three-wait-state instance on the same bus checks the wait timing.
module tb_mem_target_bank;

  localparam int AW    = 6;
  localparam int DEPTH = 2 ** AW;

  logic        CLK;
  logic        RST_N;
  logic        s_wrdn;
  logic [15:0] pci_cmd;
  logic [31:0] addr;
  logic [7:0]  base_hit;
  logic        s_data;
  logic        s_data_vld;
  logic [3:0]  s_cbe;
  logic [31:0] adio_out;
  wire  [31:0] adio_in;
  wire         s_ready, s_term, s_abort, busy;
  wire  [31:0] adio_in_w;
  wire         s_ready_w, s_term_w, s_abort_w, busy_w;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] dq[$];

  mem_target_bank #(.DW(32), .AW(AW), .NBAR(2), .WAIT_STATES(0)) u_dut (
    .CLK (CLK), .RST_N (RST_N), .s_wrdn (s_wrdn), .pci_cmd (pci_cmd),
    .addr (addr), .base_hit (base_hit), .s_data (s_data), .s_data_vld (s_data_vld),
    .s_cbe (s_cbe), .adio_out (adio_out), .adio_in (adio_in), .s_ready (s_ready),
    .s_term (s_term), .s_abort (s_abort), .busy (busy)
  );

  mem_target_bank #(.DW(32), .AW(AW), .NBAR(2), .WAIT_STATES(3)) u_dut_wait (
    .CLK (CLK), .RST_N (RST_N), .s_wrdn (s_wrdn), .pci_cmd (pci_cmd),
    .addr (addr), .base_hit (base_hit), .s_data (s_data), .s_data_vld (s_data_vld),
    .s_cbe (s_cbe), .adio_out (adio_out), .adio_in (adio_in_w), .s_ready (s_ready_w),
    .s_term (s_term_w), .s_abort (s_abort_w), .busy (busy_w)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Burst write of dq[] starting at byte address a; ws idle cycles after hit
  task automatic do_write(input int bank, input logic [31:0] a, input logic [15:0] cmd,
                          input logic [3:0] cbe, input int ws);
    int w0;
    w0 = int'(a[AW+1:2]);
    $display("WR  bank=%0d addr=%h cmd=%h cbe=%b words=%0d", bank, a, cmd, cbe, dq.size());
    base_hit = 8'(1 << bank); addr = a; pci_cmd = cmd; s_wrdn = 1'b1;
    s_data = 1'b1; s_data_vld = 1'b0; s_cbe = cbe;
    step();
    base_hit = '0;
    chk("wr_ready", 32'(s_ready), 32'd1);
    chk("wr_abort", 32'(s_abort), 32'd0);
    repeat (ws) step();
    foreach (dq[i]) begin
      chk("wr_term", 32'(s_term), ((w0 + i) >= DEPTH - 1) ? 32'd1 : 32'd0);
      s_data_vld = 1'b1; adio_out = dq[i];
      step();
    end
    s_data_vld = 1'b0; s_data = 1'b0;
    step();
    chk("wr_idle", 32'(busy), 32'd0);
  endtask

  // Burst read expecting dq[] in consecutive data phases
  task automatic do_read(input int bank, input logic [31:0] a, input logic [15:0] cmd);
    int w0;
    w0 = int'(a[AW+1:2]);
    $display("RD  bank=%0d addr=%h cmd=%h words=%0d", bank, a, cmd, dq.size());
    base_hit = 8'(1 << bank); addr = a; pci_cmd = cmd; s_wrdn = 1'b0;
    s_data = 1'b1; s_data_vld = 1'b0;
    step();
    base_hit = '0;
    chk("rd_ready", 32'(s_ready), 32'd1);
    foreach (dq[i]) begin
      chk("rd_data", adio_in, dq[i]);
      chk("rd_term", 32'(s_term), ((w0 + i) >= DEPTH - 1) ? 32'd1 : 32'd0);
      s_data_vld = 1'b1;
      step();
    end
    s_data_vld = 1'b0; s_data = 1'b0;
    step();
    chk("rd_idle", 32'(busy), 32'd0);
  endtask

  // Illegal access: abort for the whole s_data window, no ready
  task automatic do_abort(input int bank, input logic [31:0] a, input logic [15:0] cmd,
                          input logic wrdn);
    $display("ABT bank=%0d addr=%h cmd=%h wrdn=%0d", bank, a, cmd, wrdn);
    base_hit = 8'(1 << bank); addr = a; pci_cmd = cmd; s_wrdn = wrdn;
    s_data = 1'b1; s_data_vld = 1'b0; s_cbe = 4'b0000;
    step();
    base_hit = '0;
    for (int k = 0; k < 3; k++) begin
      chk("abt_abort", 32'(s_abort), 32'd1);
      chk("abt_ready", 32'(s_ready), 32'd0);
      s_data_vld = 1'b1; adio_out = 32'h1111_1111;
      step();
    end
    s_data_vld = 1'b0; s_data = 1'b0;
    step();
    chk("abt_clear", 32'(s_abort), 32'd0);
    chk("abt_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; s_wrdn = 1'b0; pci_cmd = '0; addr = '0; base_hit = '0;
    s_data = 1'b0; s_data_vld = 1'b0; s_cbe = 4'hF; adio_out = '0;
    repeat (3) step();
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_term", 32'(s_term), 32'd0);
    chk("rst_abort", 32'(s_abort), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_busy_w", 32'(busy_w), 32'd0);
    RST_N = 1'b1;
    step();

    // Single write then read
    dq = '{32'hDEAD_BEEF};
    do_write(0, 32'h10, 16'h0080, 4'b0000, 0);
    do_read(0, 32'h10, 16'h0040);

    // Known word in bank 0 before touching bank 1 (MemWriteInv)
    dq = '{32'hB0B0_0002};
    do_write(0, 32'h08, 16'h8000, 4'b0000, 0);

    // 4-word burst in bank 1, read with MemReadMult, bank 0 unchanged
    dq = '{32'h1, 32'h2, 32'h3, 32'h4};
    do_write(1, 32'h08, 16'h0080, 4'b0000, 0);
    do_read(1, 32'h08, 16'h1000);
    dq = '{32'hB0B0_0002};
    do_read(0, 32'h08, 16'h4000);

    // Byte enables
    dq = '{32'hFFFF_FFFF};
    do_write(0, 32'h20, 16'h0080, 4'b0000, 0);
    dq = '{32'h0000_0000};
    do_write(0, 32'h20, 16'h0080, 4'b1010, 0);
    dq = '{32'hFF00_FF00};
    do_read(0, 32'h20, 16'h0040);

    // Bank end: only words 62 and 63 written, pointer saturates, word 0 intact
    dq = '{32'h5A5A_0000};
    do_write(0, 32'h00, 16'h0080, 4'b0000, 0);
    dq = '{32'hE0, 32'hE1, 32'hE2};
    do_write(0, 32'hF8, 16'h0080, 4'b0000, 0);
    dq = '{32'hE0, 32'hE1, 32'hE1};
    do_read(0, 32'hF8, 16'h0040);
    dq = '{32'h5A5A_0000};
    do_read(0, 32'h00, 16'h0040);

    // Illegal accesses leave memory untouched
    do_abort(0, 32'h10, 16'h0040, 1'b1);
    do_abort(0, 32'h12, 16'h0080, 1'b1);
    dq = '{32'hDEAD_BEEF};
    do_read(0, 32'h10, 16'h0040);

    // Reset in the middle of a burst
    $display("RST mid-burst bank=1");
    base_hit = 8'h02; addr = 32'h28; pci_cmd = 16'h0080; s_wrdn = 1'b1; s_data = 1'b1;
    s_data_vld = 1'b0; s_cbe = 4'b0000;
    step();
    base_hit = '0; s_data_vld = 1'b1; adio_out = 32'h77;
    step();
    RST_N = 1'b0;
    #1;
    chk("mrst_ready", 32'(s_ready), 32'd0);
    chk("mrst_term", 32'(s_term), 32'd0);
    chk("mrst_abort", 32'(s_abort), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_busy_w", 32'(busy_w), 32'd0);
    s_data = 1'b0; s_data_vld = 1'b0;
    step();
    RST_N = 1'b1;
    step();

    // Write paced for the wait-state instance, then check its ready timing
    dq = '{32'hCAFE_0005};
    do_write(1, 32'h14, 16'h0080, 4'b0000, 3);
    $display("RD  wait-state instance bank=1 addr=%h", 32'h14);
    base_hit = 8'h02; addr = 32'h14; pci_cmd = 16'h0040; s_wrdn = 1'b0; s_data = 1'b1;
    step();
    base_hit = '0;
    for (int k = 0; k < 3; k++) begin
      chk("ws_ready_low", 32'(s_ready_w), 32'd0);
      chk("ws_busy", 32'(busy_w), 32'd1);
      step();
    end
    chk("ws_ready_high", 32'(s_ready_w), 32'd1);
    chk("ws_data", adio_in_w, 32'hCAFE_0005);
    s_data = 1'b0;
    step();
    chk("ws_idle", 32'(busy_w), 32'd0);

    // Normal transaction after reset on the zero-wait instance
    dq = '{32'hCAFE_0005};
    do_read(1, 32'h14, 16'h0040);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_target_bank.md
Name: mem_target_bank

Overview:
- Parametrised PCI target back-end: NBAR independent word-addressed memory banks behind the core's user-side target interface (base_hit, s_data, s_data_vld, adio).
- Adds several things the single-register target lacks:
  - burst transfers with auto-incrementing word pointer
  - byte enables
  - programmable initial wait states
  - disconnect at bank end
  - target abort on illegal accesses
- Sits between the PCI core and user logic as a scratch-pad/mailbox target for simulation and bring-up.

Parameters:
- DW, 32, data width; only 32 is supported by the core adio bus.
- AW, 6, log2 of words per bank (DEPTH = 2**AW).
- NBAR, 2, number of banks; bank b answers base_hit[b], 1..8.
- WAIT_STATES, 0, cycles s_ready is held low after a hit before the first data phase, 0..15.

Ports:
- CLK  in  1  core clock; all logic is on the rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- s_wrdn  in  1  1 = write (PCI to target), 0 = read.
- pci_cmd  in  16  one-hot decoded command: bit6 MemRead, bit7 MemWrite, bit12 MemReadMult, bit14 MemReadLine, bit15 MemWriteInv.
- addr  in  32  transaction start address, valid with base_hit.
- base_hit  in  8  one-cycle BAR hit strobe; bits >= NBAR are ignored.
- s_data  in  1  high for the duration of the data phase(s).
- s_data_vld  in  1  a data word is transferred this cycle.
- s_cbe  in  4  active-low byte enables for the current data phase.
- adio_out  in  32  write data from the core.
- adio_in  out  32  read data to the core; high-Z when not driving.
- s_ready  out  1  target ready for data.
- s_term  out  1  request disconnect after the current phase.
- s_abort  out  1  target abort.
- busy  out  1  transaction in progress (state != IDLE).

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE, s_ready = 0, s_term = 0, s_abort = 0, busy = 0.
  - adio_in is high-Z; pointers and wait counter = 0.
  - Bank contents are not reset.
  - Reset mid-burst returns to IDLE immediately; any data phase in flight is lost.
- Hit decode happens in the cycle base_hit[b] = 1 (lowest set b < NBAR wins). The block latches:
  - bank = b, ptr = addr[AW+1:2], dir = s_wrdn.
  - legal = (cmd matches dir) and addr[1:0] == 0.
  - Read commands: bit6, bit12, bit14. Write commands: bit7, bit15.
- States: IDLE, WAIT, XFER, ABORT.
- IDLE:
  - legal hit: go to WAIT if WAIT_STATES > 0 (counter loaded with WAIT_STATES), otherwise go straight to XFER.
  - illegal hit: go to ABORT.
  - base_hit while not IDLE is ignored.
- WAIT: s_ready = 0; counter decrements each cycle; go to XFER when it reaches 1.
- XFER:
  - s_ready = 1.
  - Write: each cycle with s_data_vld = 1, write adio_out into bank[ptr] under byte lanes whose s_cbe bit is 0, then ptr <= ptr + 1.
  - Read:
    - Read data is prefetched into a register, so adio_in = rdq whenever state == XFER and s_data == 1.
    - rdq holds bank[ptr] and is valid on entry to XFER (latency: 1 cycle from hit when WAIT_STATES = 0).
    - On s_data_vld, ptr advances and rdq is updated to the new word for the next cycle.
  - s_term = 1 while ptr == DEPTH-1: the last word of the bank completes and the core disconnects. ptr never wraps within a transaction.
  - s_data falling: return to IDLE, with s_ready = s_term = 0 on the next cycle.
- ABORT:
  - s_abort = 1, s_ready = 0, no bank access, adio_in high-Z.
  - Leave to IDLE when s_data == 0.
- Simultaneous s_data_vld and ptr == DEPTH-1: that write/read completes. ptr saturates at DEPTH-1; there is no further access even if s_data_vld repeats.
- Banks are independent: writing bank 0 never alters bank 1.

Decomposition:
- Shared package:
  - pci_cmd one-hot bit indices (CMD_MRD = 6, CMD_MWR = 7, CMD_MRM = 12, CMD_MRL = 14, CMD_MWI = 15).
  - state encoding.
  - read/write command mask constants.
- One sub-module, mem_target_ram:
  - single-port DW x DEPTH with 4 byte-lane write enables and a registered read.
  - instantiated NBAR times.
  - read mux selected by the latched bank.

Test Plan:
- Single write then read, bank 0, addr 0x10, cmd 0x0080, data 0xDEADBEEF, s_cbe = 0 -> read (cmd 0x0040) returns 0xDEADBEEF; s_ready rises 1 cycle after hit; s_abort stays 0.
- 4-word burst write 0x1..0x4 at word 2 of bank 1, then a burst read with cmd 0x1000 -> 0x1, 0x2, 0x3, 0x4 in consecutive s_data_vld cycles; bank 0 unchanged.
- Byte enables: write 0xFFFFFFFF, then write 0x00000000 with s_cbe = 4'b1010 -> read gives 0xFF00FF00.
- Burst write starting at word DEPTH-2 -> s_term high on the phase at DEPTH-1; exactly 2 words written; word 0 untouched.
- Illegal accesses: read cmd with s_wrdn = 1, and addr 0x...02 -> s_abort = 1 for the whole s_data window, s_ready = 0, memory unchanged.
- WAIT_STATES = 3: s_ready is low for 3 cycles after the hit and then high. RST_N pulsed mid-burst -> all outputs 0, adio_in high-Z, and the next transaction works normally.
